conv3x3_stream: RTL and testbench
=================================

CONV3X3_STREAM -- requirements
Module: conv3x3_stream

Interface
REQ-001 Parameter DW, default 12, pixel data width in bits.
REQ-002 Parameter XW, default 11, coordinate width in bits.
REQ-003 Parameter IMG_W, default 640, maximum line length in pixels; sets the depth of each line buffer.
REQ-004 clk  input  1  clock; all logic is rising-edge triggered.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  input pixel qualifier; a pixel is accepted on any rising edge where in_valid=1.
REQ-007 in_x  input  XW  column of the input pixel, 0..IMG_W-1.
REQ-008 in_y  input  XW  row of the input pixel.
REQ-009 in_data  input  DW  unsigned input pixel value.
REQ-010 mode  input  2  filter select: 0 passthrough, 1 |Gx| Sobel, 2 |Gy| Sobel, 3 Gaussian 3x3.
REQ-011 out_valid  output  1  output pixel qualifier.
REQ-012 out_x, out_y  output  XW each  coordinates of the accepted input pixel, delayed to align with out_data.
REQ-013 out_data  output  DW  filtered result.
REQ-014 active_mode  output  2  mode currently applied.

Function
REQ-015 Two line buffers, each IMG_W x DW; on each acceptance, LB0[in_x] is read as pixel (x,y-1) and LB1[in_x] as pixel (x,y-2); then LB1[in_x] <= old LB0[in_x] and LB0[in_x] <= in_data.
REQ-016 The 3x3 window shifts by one column only on acceptance; the new right column is {LB1 read, LB0 read, in_data}, ordered top to bottom.
REQ-017 The window whose bottom-right pixel is (in_x,in_y) is centred on (in_x-1,in_y-1); the result for that window is reported with out_x=in_x and out_y=in_y.
REQ-018 Fixed latency: a pixel accepted at edge k produces out_valid=1 after edge k+2; exactly one output per accepted pixel, in input order.
REQ-019 No bubbles are inserted or removed: gaps in in_valid appear as out_valid=0 gaps with the same 2-cycle offset.
REQ-020 Mode 0: out_data = the in_data of the same accepted pixel; the window contents are ignored.
REQ-021 Mode 1: Gx = (right column sum weighted 1,2,1) - (left column sum weighted 1,2,1), signed DW+4 bits; out_data = |Gx| saturated to 2^DW-1.
REQ-022 Mode 2: Gy = (bottom row weighted 1,2,1) - (top row weighted 1,2,1); out_data = |Gy| saturated to 2^DW-1.
REQ-023 Mode 3: weights [1 2 1; 2 4 2; 1 2 1] are summed unsigned in DW+4 bits; out_data = sum >> 4, truncated, never exceeding 2^DW-1.
REQ-024 Border: in modes 1-3, out_data = 0 when in_x<2 or in_y<2 (incomplete window); mode 0 is unaffected by this rule.
REQ-025 Mode latch: active_mode <= mode only on acceptance of a pixel with in_x=0 and in_y=0 (frame start); that pixel and all later pixels use the new mode.
REQ-026 A mode change mid-frame has no effect until the next frame start.
REQ-027 A pixel with in_x >= IMG_W is dropped: no line-buffer write, no window shift, no output.
REQ-028 Line-buffer contents are not cleared at frame start; the REQ-024 zeroing masks stale data.

Reset
REQ-029 While rst_n=0 at a rising edge: out_valid=0, out_data=0, out_x=0, out_y=0, active_mode=0, and all pipeline valid bits are cleared.
REQ-030 Line-buffer and window data need not be reset.
REQ-031 Reset mid-frame: out_valid=0 from the first edge with rst_n=0; pixels in flight are discarded.
REQ-032 After reset, the first output appears 2 edges after the first accepted pixel.

Verification
REQ-033 64x48 frame, all pixels 0x100, mode=3 at frame start -> out_data=0x100 wherever x>=2 and y>=2, 0x000 elsewhere; 3072 outputs.
REQ-034 Horizontal ramp in_data=x*16, mode=1 -> 0x080 for x>=2, y>=2; same frame with mode=2 -> 0x000.
REQ-035 Step image, 0 for x<3 and 0xFFF for x>=3, mode=1 -> window at x=3 (y>=2) outputs 0xFFF (saturated, unsaturated value 0x3FFC); x=5 outputs 0x000.
REQ-036 mode changed 0->2 mid-frame -> active_mode stays 0 and outputs equal inputs until the next (0,0) acceptance; from that pixel onward, mode 2 applies.
REQ-037 in_valid toggled 1,0,1,1 with distinct data, mode=0 -> out_valid pattern 1,0,1,1 starting 2 edges later, with matching data and coordinates.
REQ-038 rst_n asserted for 1 cycle at pixel 1000 -> out_valid=0 and active_mode=0 on the next edge; the first output after deassertion appears 2 edges after the next acceptance.

Source files
------------

// File: rtl/conv3x3_stream.sv
// 3x3 streaming convolution over a raster pixel stream.
// Two line buffers feed a sliding 3x3 window. The selectable filters are
// passthrough, |Gx| Sobel, |Gy| Sobel and 3x3 Gaussian.
// An accepted pixel's result appears exactly two edges after acceptance.
module conv3x3_stream #(
   parameter int DW    = 12,
   parameter int XW    = 11,
   parameter int IMG_W = 640
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [XW-1:0] in_x,
   input  logic [XW-1:0] in_y,
   input  logic [DW-1:0] in_data,
   input  logic [1:0]    mode,
   output logic          out_valid,
   output logic [XW-1:0] out_x,
   output logic [XW-1:0] out_y,
   output logic [DW-1:0] out_data,
   output logic [1:0]    active_mode
);

   localparam int            AW        = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int            SW        = DW + 4;
   localparam logic [XW:0]   IMG_W_EXT = (XW+1)'(IMG_W);

   typedef enum logic [1:0] {
      MODE_PASS  = 2'd0,
      MODE_GX    = 2'd1,
      MODE_GY    = 2'd2,
      MODE_GAUSS = 2'd3
   } mode_e;

   // line buffers: lb0 holds row y-1, lb1 holds row y-2
   logic [DW-1:0] lb0 [IMG_W];
   logic [DW-1:0] lb1 [IMG_W];

   // window: win[row][col], row 0 = top, col 2 = newest (rightmost)
   logic [DW-1:0] win [3][3];

   logic          accept;
   logic          frame_start;
   logic [AW-1:0] addr;
   logic [DW-1:0] lb0_rd;
   logic [DW-1:0] lb1_rd;
   mode_e         eff_mode;

   // stage 1: registered attributes of the pixel that last shifted the window
   logic          s1_valid;
   logic [XW-1:0] s1_x;
   logic [XW-1:0] s1_y;
   logic [DW-1:0] s1_data;
   mode_e         s1_mode;

   // stage 2: raw filter sums, awaiting magnitude/saturation
   logic                 s2_valid;
   logic [XW-1:0]        s2_x;
   logic [XW-1:0]        s2_y;
   logic [DW-1:0]        s2_data;
   mode_e                s2_mode;
   logic                 s2_border;
   logic signed [SW-1:0] s2_gx;
   logic signed [SW-1:0] s2_gy;
   logic [DW-1:0]        s2_gs;

   // combinational filter arithmetic
   logic [SW-1:0]        col_l;
   logic [SW-1:0]        col_r;
   logic [SW-1:0]        row_t;
   logic [SW-1:0]        row_m;
   logic [SW-1:0]        row_b;
   logic signed [SW-1:0] gx_c;
   logic signed [SW-1:0] gy_c;
   logic [SW-1:0]        gs_sum;

   logic [SW-1:0]        mag_gx;
   logic [SW-1:0]        mag_gy;
   logic [DW-1:0]        result;

   // a*1 + b*2 + c*1 in the widened arithmetic width
   function automatic logic [SW-1:0] wsum(input logic [DW-1:0] a,
                                          input logic [DW-1:0] b,
                                          input logic [DW-1:0] c);
      return SW'(a) + (SW'(b) << 1) + SW'(c);
   endfunction

   // clamp a non-negative magnitude to the pixel range
   function automatic logic [DW-1:0] sat(input logic [SW-1:0] v);
      return (|v[SW-1:DW]) ? '1 : v[DW-1:0];
   endfunction

   assign accept      = in_valid && ({1'b0, in_x} < IMG_W_EXT);
   assign frame_start = accept && (in_x == '0) && (in_y == '0);
   assign addr        = in_x[AW-1:0];
   assign eff_mode    = frame_start ? mode_e'(mode) : mode_e'(active_mode);

   // asynchronous read of both line buffers at the incoming column
   always_comb begin
      lb0_rd = lb0[addr];
      lb1_rd = lb1[addr];
   end

   // line buffer update: shift column down one row, insert new pixel
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[addr] <= lb0_rd;
         lb0[addr] <= in_data;
      end
   end

   // window shift on acceptance; new right column is {row y-2, row y-1, row y}
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int unsigned r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2] <= lb1_rd;
         win[1][2] <= lb0_rd;
         win[2][2] <= in_data;
      end
   end

   // frame-start mode latch and stage-1 valid
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active_mode <= '0;
         s1_valid    <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (frame_start)
            active_mode <= mode;
      end
   end

   // stage-1 pixel attributes, travelling alongside the window
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_x    <= in_x;
         s1_y    <= in_y;
         s1_data <= in_data;
         s1_mode <= eff_mode;
      end
   end

   // column/row weighted sums of the current window
   always_comb begin
      col_l  = wsum(win[0][0], win[1][0], win[2][0]);
      col_r  = wsum(win[0][2], win[1][2], win[2][2]);
      row_t  = wsum(win[0][0], win[0][1], win[0][2]);
      row_m  = wsum(win[1][0], win[1][1], win[1][2]);
      row_b  = wsum(win[2][0], win[2][1], win[2][2]);
      gx_c   = signed'(col_r - col_l);
      gy_c   = signed'(row_b - row_t);
      gs_sum = row_t + (row_m << 1) + row_b;
   end

   // stage-2 valid
   always_ff @(posedge clk) begin
      if (!rst_n)
         s2_valid <= 1'b0;
      else
         s2_valid <= s1_valid;
   end

   // stage-2 sums and attributes
   always_ff @(posedge clk) begin
      if (s1_valid) begin
         s2_x      <= s1_x;
         s2_y      <= s1_y;
         s2_data   <= s1_data;
         s2_mode   <= s1_mode;
         s2_border <= (s1_x < XW'(2)) || (s1_y < XW'(2));
         s2_gx     <= gx_c;
         s2_gy     <= gy_c;
         s2_gs     <= DW'(gs_sum >> 4);
      end
   end

   // magnitude, saturation, mode select and border masking
   always_comb begin
      mag_gx = s2_gx[SW-1] ? unsigned'(-s2_gx) : unsigned'(s2_gx);
      mag_gy = s2_gy[SW-1] ? unsigned'(-s2_gy) : unsigned'(s2_gy);
      result = '0;
      case (s2_mode)
         MODE_PASS: result = s2_data;
         MODE_GX:   result = sat(mag_gx);
         MODE_GY:   result = sat(mag_gy);
         default:   result = s2_gs;
      endcase
      if ((s2_mode != MODE_PASS) && s2_border)
         result = '0;
   end

   // output register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_x     <= '0;
         out_y     <= '0;
         out_data  <= '0;
      end else begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            out_x    <= s2_x;
            out_y    <= s2_y;
            out_data <= result;
         end
      end
   end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream: frames with hand-derived expected results.
module tb_conv3x3_stream;

   localparam int DW    = 12;
   localparam int XW    = 11;
   localparam int IMG_W = 64;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic [XW-1:0] in_x;
   logic [XW-1:0] in_y;
   logic [DW-1:0] in_data;
   logic [1:0]    mode;
   logic          out_valid;
   logic [XW-1:0] out_x;
   logic [XW-1:0] out_y;
   logic [DW-1:0] out_data;
   logic [1:0]    active_mode;

   int checks = 0;
   int passed = 0;
   int nvalid = 0;

   // expectation delay line: slot 0 newest, slot 2 due at this sample
   logic  pv [3];
   int    px [3];
   int    py [3];
   int    pd [3];
   string pt [3];

   conv3x3_stream #(.DW(DW), .XW(XW), .IMG_W(IMG_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_x        (in_x),
      .in_y        (in_y),
      .in_data     (in_data),
      .mode        (mode),
      .out_valid   (out_valid),
      .out_x       (out_x),
      .out_y       (out_y),
      .out_data    (out_data),
      .active_mode (active_mode)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic clear_pipe();
      for (int i = 0; i < 3; i++) begin
         pv[i] = 1'b0; px[i] = 0; py[i] = 0; pd[i] = 0; pt[i] = "idle";
      end
   endtask

   // one cycle: check the output due now, then drive the next input
   task automatic step(input logic v, input int x, input int y, input int d,
                       input logic [1:0] m, input logic ev, input int ed, input string tag);
      @(negedge clk);
      if (out_valid === 1'b1) nvalid++;
      chk({pt[2], ".valid"}, {31'd0, out_valid}, {31'd0, pv[2]});
      if (pv[2]) begin
         chk({pt[2], ".data"}, {20'd0, out_data}, pd[2]);
         chk({pt[2], ".x"}, {21'd0, out_x}, px[2]);
         chk({pt[2], ".y"}, {21'd0, out_y}, py[2]);
      end
      for (int i = 2; i > 0; i--) begin
         pv[i] = pv[i-1]; px[i] = px[i-1]; py[i] = py[i-1]; pd[i] = pd[i-1]; pt[i] = pt[i-1];
      end
      pv[0] = ev; px[0] = x; py[0] = y; pd[0] = ed; pt[0] = tag;
      in_valid = v;
      in_x     = x[XW-1:0];
      in_y     = y[XW-1:0];
      in_data  = d[DW-1:0];
      mode     = m;
   endtask

   task automatic flush();
      repeat (3) step(1'b0, 0, 0, 0, 2'd0, 1'b0, 0, "flush");
   endtask

   initial begin
      int  ev_data;
      logic after_rst;
      clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0;
      in_data = '0; mode = 2'd0;
      clear_pipe();

      // reset state
      repeat (3) @(negedge clk);
      chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst.out_data", {20'd0, out_data}, 32'd0);
      chk("rst.out_x", {21'd0, out_x}, 32'd0);
      chk("rst.out_y", {21'd0, out_y}, 32'd0);
      chk("rst.active_mode", {30'd0, active_mode}, 32'd0);
      rst_n = 1'b1;

      // flat 0x100 frame, Gaussian: 16*0x100 >> 4 = 0x100 inside the border
      nvalid = 0;
      for (int y = 0; y < 48; y++)
         for (int x = 0; x < 64; x++)
            step(1'b1, x, y, 'h100, 2'd3, 1'b1, (x >= 2 && y >= 2) ? 'h100 : 0, "gauss_flat");
      flush();
      chk("gauss_flat.count", nvalid, 3072);
      chk("gauss_flat.active_mode", {30'd0, active_mode}, 32'd3);

      // horizontal ramp x*16, |Gx| = 4*16*2 = 0x080; one out-of-range pixel dropped mid-frame
      for (int y = 0; y < 6; y++)
         for (int x = 0; x < 64; x++) begin
            if (y == 3 && x == 10)
               step(1'b1, 64, 3, 'hFFF, 2'd1, 1'b0, 0, "drop_ramp");
            step(1'b1, x, y, x * 16, 2'd1, 1'b1, (x >= 2 && y >= 2) ? 'h080 : 0, "ramp_gx");
         end
      flush();
      chk("ramp_gx.active_mode", {30'd0, active_mode}, 32'd1);

      // same ramp, |Gy| is zero everywhere
      for (int y = 0; y < 6; y++)
         for (int x = 0; x < 64; x++)
            step(1'b1, x, y, x * 16, 2'd2, 1'b1, 0, "ramp_gy");
      flush();

      // step edge at x=3: windows at x=3,4 saturate (raw 0x3FFC), x>=5 flat
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 64; x++)
            step(1'b1, x, y, (x >= 3) ? 'hFFF : 0, 2'd1, 1'b1,
                 (y >= 2 && (x == 3 || x == 4)) ? 'hFFF : 0, "step_gx");
      flush();

      // mode request 0 -> 2 mid-frame: stays passthrough until next frame start
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 64; x++)
            step(1'b1, x, y, y * 16 + 5 + x, (y >= 2) ? 2'd2 : 2'd0, 1'b1,
                 y * 16 + 5 + x, "midframe_pass");
      flush();
      chk("midframe.active_mode", {30'd0, active_mode}, 32'd0);

      // next frame applies mode 2: vertical ramp y*16+5 gives |Gy| = 0x080
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 64; x++)
            step(1'b1, x, y, y * 16 + 5, 2'd2, 1'b1,
                 (x >= 2 && y >= 2) ? 'h080 : 0, "newframe_gy");
      flush();
      chk("newframe.active_mode", {30'd0, active_mode}, 32'd2);

      // in_valid 1,0,1,1 in passthrough; then out-of-range pixels dropped
      step(1'b1, 0, 0, 'h3A1, 2'd0, 1'b1, 'h3A1, "gap_a");
      step(1'b0, 1, 0, 'h7FF, 2'd0, 1'b0, 0, "gap_b");
      step(1'b1, 1, 0, 'h5C2, 2'd0, 1'b1, 'h5C2, "gap_c");
      step(1'b1, 2, 0, 'h0E3, 2'd0, 1'b1, 'h0E3, "gap_d");
      step(1'b1, 64, 0, 'h123, 2'd0, 1'b0, 0, "drop_a");
      step(1'b1, 100, 0, 'h321, 2'd0, 1'b0, 0, "drop_b");
      step(1'b1, 3, 0, 'h456, 2'd0, 1'b1, 'h456, "gap_e");
      flush();
      chk("gap.active_mode", {30'd0, active_mode}, 32'd0);

      // Gaussian frame with a one-cycle reset at pixel 1000; afterwards mode is 0
      after_rst = 1'b0;
      for (int y = 0; y < 18; y++)
         for (int x = 0; x < 64; x++) begin
            if (y * 64 + x == 1000) begin
               @(negedge clk);
               rst_n = 1'b0;
               in_valid = 1'b0;
               clear_pipe();
               @(negedge clk);
               chk("midrst.out_valid", {31'd0, out_valid}, 32'd0);
               chk("midrst.active_mode", {30'd0, active_mode}, 32'd0);
               chk("midrst.out_data", {20'd0, out_data}, 32'd0);
               rst_n = 1'b1;
               after_rst = 1'b1;
            end
            if (after_rst) ev_data = 'h100;
            else ev_data = (x >= 2 && y >= 2) ? 'h100 : 0;
            step(1'b1, x, y, 'h100, 2'd3, 1'b1, ev_data, after_rst ? "post_rst" : "pre_rst");
         end
      flush();
      chk("post_rst.active_mode", {30'd0, active_mode}, 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
